// File: rtl/mc_timer_if.sv
// Register bus between a host and mc_timer.
// A read strobe returns registered data with a one-cycle valid pulse.
interface mc_timer_if #(
   parameter int WIDTH = 32
);
   logic [3:0]       addr;
   logic             wr_en;
   logic             rd_en;
   logic [WIDTH-1:0] wr_data;
   logic [WIDTH-1:0] rd_data;
   logic             rd_valid;

   modport master (
      output addr, wr_en, rd_en, wr_data,
      input  rd_data, rd_valid
   );

   modport slave (
      input  addr, wr_en, rd_en, wr_data,
      output rd_data, rd_valid
   );
endinterface

// File: rtl/mc_timer.sv
// Multi-channel timer: a prescaled up-counter with compare and capture channels,
// sticky W1C status and a level interrupt, accessed through mc_timer_if.
module mc_timer #(
   parameter int WIDTH    = 32,
   parameter int CHANNELS = 4
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                timer_rst,
   mc_timer_if.slave           bus,
   input  logic [CHANNELS-1:0] cap_in,
   output logic                irq,
   output logic [WIDTH-1:0]    count
);

   logic [2:0]          ctrl_q, ctrl_d;
   logic [WIDTH-1:0]    prescale_q, prescale_d;
   logic [WIDTH-1:0]    count_q, count_d;
   logic [WIDTH-1:0]    pcnt_q, pcnt_d;
   logic [16:0]         status_q, status_d;
   logic [16:0]         irqEn_q, irqEn_d;
   logic [WIDTH-1:0]    cmp_q [CHANNELS];
   logic [WIDTH-1:0]    cmp_d [CHANNELS];
   logic [WIDTH-1:0]    cap_q [CHANNELS];
   logic [WIDTH-1:0]    cap_d [CHANNELS];
   logic [CHANNELS-1:0] sync1_q, sync2_q, sync3_q;
   logic [WIDTH-1:0]    rdData_q, rdData_d;
   logic                rdValid_q;

   logic                tick, wrap, countWr;
   logic [16:0]         wrData17, statusSet, statusClr;
   logic [CHANNELS-1:0] capEdge;
   logic [WIDTH-1:0]    rdMux;

   assign wrData17 = 17'(bus.wr_data);
   assign countWr  = bus.wr_en && (bus.addr == 4'd2);
   assign tick     = ctrl_q[0] && (pcnt_q == prescale_q);
   assign wrap     = tick && ctrl_q[1] && (count_q == cmp_q[0]);
   assign capEdge  = sync2_q & ~sync3_q;

   // Read data is taken from the current registers, so a simultaneous write is not yet visible.
   always_comb begin
      rdMux = '0;
      case (bus.addr)
         4'd0:    rdMux = WIDTH'(ctrl_q);
         4'd1:    rdMux = prescale_q;
         4'd2:    rdMux = count_q;
         4'd3:    rdMux = WIDTH'(status_q);
         4'd4:    rdMux = WIDTH'(irqEn_q);
         default: rdMux = '0;
      endcase
      for (int k = 0; k < CHANNELS; k++) begin
         if (bus.addr == 4'(8 + 2 * k)) rdMux = cmp_q[k];
         if (bus.addr == 4'(9 + 2 * k)) rdMux = cap_q[k];
      end
   end

   // Next-state: hardware status sets are OR-ed after the W1C clear so a coincident event wins.
   always_comb begin
      ctrl_d     = ctrl_q;
      prescale_d = prescale_q;
      irqEn_d    = irqEn_q;
      cmp_d      = cmp_q;
      cap_d      = cap_q;
      count_d    = count_q;
      pcnt_d     = pcnt_q;
      statusSet  = '0;
      statusClr  = '0;
      rdData_d   = bus.rd_en ? rdMux : rdData_q;

      for (int k = 0; k < CHANNELS; k++) begin
         if (tick && (count_q == cmp_q[k])) statusSet[k] = 1'b1;
         if (capEdge[k]) begin
            cap_d[k]         = count_q;
            statusSet[8 + k] = 1'b1;
         end
      end
      if (tick && !wrap && (count_q == '1)) statusSet[16] = 1'b1;

      if (bus.wr_en) begin
         case (bus.addr)
            4'd0:    ctrl_d     = bus.wr_data[2:0];
            4'd1:    prescale_d = bus.wr_data;
            4'd3:    statusClr  = wrData17;
            4'd4:    irqEn_d    = wrData17;
            default: ;
         endcase
         for (int k = 0; k < CHANNELS; k++) begin
            if (bus.addr == 4'(8 + 2 * k)) cmp_d[k] = bus.wr_data;
         end
      end
      status_d = (status_q & ~statusClr) | statusSet;

      if (timer_rst) begin
         count_d = '0;
         pcnt_d  = '0;
      end else if (countWr) begin
         count_d = bus.wr_data;
         pcnt_d  = '0;
      end else if (ctrl_q[0]) begin
         if (tick) begin
            pcnt_d  = '0;
            count_d = wrap ? '0 : count_q + 1'b1;
         end else begin
            pcnt_d = pcnt_q + 1'b1;
         end
      end

      if (wrap && ctrl_q[2] && !timer_rst && !countWr) ctrl_d[0] = 1'b0;
   end

   // State registers, including the capture synchronisers.
   always_ff @(posedge clk) begin
      if (rst) begin
         ctrl_q     <= '0;
         prescale_q <= '0;
         count_q    <= '0;
         pcnt_q     <= '0;
         status_q   <= '0;
         irqEn_q    <= '0;
         sync1_q    <= '0;
         sync2_q    <= '0;
         sync3_q    <= '0;
         rdData_q   <= '0;
         rdValid_q  <= 1'b0;
         for (int k = 0; k < CHANNELS; k++) begin
            cmp_q[k] <= '0;
            cap_q[k] <= '0;
         end
      end else begin
         ctrl_q     <= ctrl_d;
         prescale_q <= prescale_d;
         count_q    <= count_d;
         pcnt_q     <= pcnt_d;
         status_q   <= status_d;
         irqEn_q    <= irqEn_d;
         sync1_q    <= cap_in;
         sync2_q    <= sync1_q;
         sync3_q    <= sync2_q;
         rdData_q   <= rdData_d;
         rdValid_q  <= bus.rd_en;
         cmp_q      <= cmp_d;
         cap_q      <= cap_d;
      end
   end

   assign bus.rd_data  = rdData_q;
   assign bus.rd_valid = rdValid_q;
   assign irq          = |(status_q & irqEn_q);
   assign count        = count_q;

endmodule

// File: tb/tb_mc_timer.sv
// Testbench for mc_timer: directed scenarios then random traffic, every cycle
// compared against a behavioural register-level model of the timer.
module tb_mc_timer;
   localparam int W  = 32;
   localparam int CH = 4;

   logic          clk = 1'b0;
   logic          rst;
   logic          timer_rst;
   logic [CH-1:0] cap_in;
   logic          irq;
   logic [W-1:0]  count;

   mc_timer_if #(.WIDTH(W)) bus ();

   mc_timer #(.WIDTH(W), .CHANNELS(CH)) dut (
      .clk       (clk),
      .rst       (rst),
      .timer_rst (timer_rst),
      .bus       (bus),
      .cap_in    (cap_in),
      .irq       (irq),
      .count     (count)
   );

   always #5 clk = ~clk;

   int vectors     = 0;
   int miscompares = 0;

   logic [3:0]  capVal;
   logic [2:0]  mCtrl;
   logic [31:0] mPre, mCount, mPcnt, mRd;
   logic [16:0] mStat, mIe;
   logic [31:0] mCmp [CH];
   logic [31:0] mCap [CH];
   logic [3:0]  hist [3];
   logic        mRv;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("[TB] FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   function automatic logic [31:0] modelRead(input logic [3:0] a);
      logic [31:0] v;
      v = 32'h0;
      case (a)
         4'd0:    v = 32'(mCtrl);
         4'd1:    v = mPre;
         4'd2:    v = mCount;
         4'd3:    v = 32'(mStat);
         4'd4:    v = 32'(mIe);
         default: v = 32'h0;
      endcase
      for (int k = 0; k < CH; k++) begin
         if (a == 4'(8 + 2 * k)) v = mCmp[k];
         if (a == 4'(9 + 2 * k)) v = mCap[k];
      end
      return v;
   endfunction

   task automatic modelReset();
      mCtrl = '0; mPre = '0; mCount = '0; mPcnt = '0; mRd = '0;
      mStat = '0; mIe = '0; mRv = 1'b0;
      for (int k = 0; k < CH; k++) begin
         mCmp[k] = '0;
         mCap[k] = '0;
      end
      for (int j = 0; j < 3; j++) hist[j] = '0;
   endtask

   // One clock of the timer's behaviour; hist[0] is cap_in as sampled one edge ago.
   task automatic modelStep(input logic [3:0] a, input logic we, input logic re,
                            input logic [31:0] wd, input logic trst, input logic [3:0] cap);
      logic        tick, wrap, stop, cntWr;
      logic [31:0] oldCount;
      logic [16:0] sets, clr;
      oldCount = mCount;
      sets     = '0;
      clr      = '0;
      cntWr    = we && (a == 4'd2);
      if (re) mRd = modelRead(a);
      mRv  = re;
      tick = mCtrl[0] && (mPcnt == mPre);
      wrap = tick && mCtrl[1] && (mCount == mCmp[0]);
      stop = wrap && mCtrl[2] && !trst && !cntWr;
      for (int k = 0; k < CH; k++) begin
         if (tick && mCount == mCmp[k]) sets[k] = 1'b1;
         if (hist[1][k] && !hist[2][k]) begin
            mCap[k]      = oldCount;
            sets[8 + k]  = 1'b1;
         end
      end
      if (tick && !wrap && mCount == 32'hFFFF_FFFF) sets[16] = 1'b1;
      hist[2] = hist[1];
      hist[1] = hist[0];
      hist[0] = cap;
      if (we && a == 4'd3) clr = wd[16:0];
      mStat = (mStat & ~clr) | sets;
      if (trst) begin
         mCount = 0; mPcnt = 0;
      end else if (cntWr) begin
         mCount = wd; mPcnt = 0;
      end else if (mCtrl[0]) begin
         if (tick) begin
            mPcnt  = 0;
            mCount = wrap ? 32'h0 : mCount + 1;
         end else begin
            mPcnt = mPcnt + 1;
         end
      end
      if (we) begin
         if (a == 4'd0) mCtrl = wd[2:0];
         if (a == 4'd1) mPre = wd;
         if (a == 4'd4) mIe = wd[16:0];
         for (int k = 0; k < CH; k++) if (a == 4'(8 + 2 * k)) mCmp[k] = wd;
      end
      if (stop) mCtrl[0] = 1'b0;
   endtask

   task automatic checkOutput();
      check("count", count, mCount);
      check("irq", 32'(irq), 32'(|(mStat & mIe)));
      check("rd_valid", 32'(bus.rd_valid), 32'(mRv));
      check("rd_data", bus.rd_data, mRd);
   endtask

   // Drives one cycle of inputs at the falling edge and checks after the next rising edge.
   task automatic applyStimulus(input logic [3:0] a, input logic we, input logic re,
                                input logic [31:0] wd, input logic trst, input logic [3:0] cap);
      bus.addr    = a;
      bus.wr_en   = we;
      bus.rd_en   = re;
      bus.wr_data = wd;
      timer_rst   = trst;
      cap_in      = cap;
      modelStep(a, we, re, wd, trst, cap);
      @(negedge clk);
      checkOutput();
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) applyStimulus(4'd0, 1'b0, 1'b0, 32'h0, 1'b0, capVal);
   endtask

   task automatic writeReg(input logic [3:0] a, input logic [31:0] d);
      applyStimulus(a, 1'b1, 1'b0, d, 1'b0, capVal);
   endtask

   task automatic readReg(input logic [3:0] a, output logic [31:0] v);
      applyStimulus(a, 1'b0, 1'b1, 32'h0, 1'b0, capVal);
      v = bus.rd_data;
   endtask

   task automatic doReset();
      rst         = 1'b1;
      bus.addr    = '0;
      bus.wr_en   = 1'b0;
      bus.rd_en   = 1'b0;
      bus.wr_data = '0;
      timer_rst   = 1'b0;
      capVal      = '0;
      cap_in      = '0;
      @(negedge clk);
      @(negedge clk);
      rst = 1'b0;
      modelReset();
      checkOutput();
   endtask

   task automatic randomPhase(input int n);
      logic [3:0]  a;
      logic        we, re, trst;
      logic [31:0] wd;
      int          r;
      for (int i = 0; i < n; i++) begin
         r  = $urandom_range(0, 99);
         a  = 4'($urandom_range(0, 15));
         we = (r < 15);
         re = (r >= 10) && (r < 35);
         case (a)
            4'd0: begin
               wd = 32'($urandom_range(0, 15));
               if ($urandom_range(0, 3) != 0) wd[0] = 1'b1;
            end
            4'd1: wd = 32'($urandom_range(0, 3));
            4'd2: wd = ($urandom_range(0, 1) == 1) ? 32'($urandom_range(0, 20))
                                                   : 32'hFFFF_FFF0 + 32'($urandom_range(0, 15));
            4'd8, 4'd10, 4'd12, 4'd14: wd = 32'($urandom_range(0, 24));
            default: wd = $urandom;
         endcase
         trst = ($urandom_range(0, 49) == 0);
         if ($urandom_range(0, 9) == 0) capVal = 4'($urandom);
         applyStimulus(a, we, re, wd, trst, capVal);
      end
   endtask

   initial begin
      logic [31:0] v;

      doReset();
      check("reset_count", count, 32'h0);
      check("reset_irq", 32'(irq), 32'h0);
      check("reset_rd_valid", 32'(bus.rd_valid), 32'h0);
      readReg(4'd1, v);
      check("reset_prescale", v, 32'h0);

      // Prescale 3 gives one increment every four cycles.
      writeReg(4'd1, 32'd3);
      writeReg(4'd0, 32'd1);
      idle(40);
      check("prescale_count", count, 32'd10);

      // One-shot period mode: wrap at CMP0, EN drops, irq until W1C.
      doReset();
      writeReg(4'd8, 32'd5);
      writeReg(4'd10, 32'd100);
      writeReg(4'd12, 32'd100);
      writeReg(4'd14, 32'd100);
      writeReg(4'd4, 32'h1);
      writeReg(4'd0, 32'd7);
      idle(5);
      check("period_peak", count, 32'd5);
      idle(1);
      check("period_wrap", count, 32'd0);
      readReg(4'd0, v);
      check("oneshot_ctrl", v, 32'd6);
      check("cmp_irq", 32'(irq), 32'h1);
      readReg(4'd3, v);
      check("cmp_status", v, 32'h1);
      writeReg(4'd3, 32'h1);
      check("irq_cleared", 32'(irq), 32'h0);
      check("oneshot_halt", count, 32'd0);

      // Overflow from all-ones.
      doReset();
      writeReg(4'd2, 32'hFFFF_FFFE);
      writeReg(4'd0, 32'd1);
      idle(1);
      check("ovf_pre", count, 32'hFFFF_FFFF);
      idle(1);
      check("ovf_count", count, 32'h0);
      writeReg(4'd0, 32'd0);
      readReg(4'd3, v);
      check("ovf_status", 32'(v[16]), 32'h1);

      // Capture on channel 2 with a stopped counter.
      doReset();
      writeReg(4'd4, 32'h400);
      writeReg(4'd2, 32'h40);
      capVal = 4'b0100;
      idle(2);
      check("cap_latency", 32'(irq), 32'h0);
      idle(1);
      check("cap_irq", 32'(irq), 32'h1);
      readReg(4'd13, v);
      check("cap2_value", v, 32'h40);
      readReg(4'd3, v);
      check("cap_status", v, 32'h400);

      // Reset mid-count with a capture edge in flight.
      doReset();
      writeReg(4'd0, 32'd1);
      capVal = 4'b0001;
      idle(1);
      capVal = 4'b0000;
      doReset();
      check("midrst_count", count, 32'h0);
      idle(4);
      readReg(4'd3, v);
      check("midrst_status", v, 32'h0);

      // W1C collides with a new compare-0 match.
      doReset();
      writeReg(4'd8, 32'd3);
      writeReg(4'd10, 32'd100);
      writeReg(4'd12, 32'd100);
      writeReg(4'd14, 32'd100);
      writeReg(4'd0, 32'd3);
      idle(7);
      writeReg(4'd3, 32'h1);
      readReg(4'd3, v);
      check("w1c_collide", v, 32'h1);
      writeReg(4'd3, 32'h1);
      readReg(4'd3, v);
      check("w1c_plain", v, 32'h0);

      // Simultaneous read and write, unmapped and read-only addresses.
      doReset();
      writeReg(4'd10, 32'h55);
      applyStimulus(4'd10, 1'b1, 1'b1, 32'd7, 1'b0, capVal);
      check("rw_valid", 32'(bus.rd_valid), 32'h1);
      check("rw_old", bus.rd_data, 32'h55);
      readReg(4'd10, v);
      check("rw_new", v, 32'd7);
      writeReg(4'd5, 32'd123);
      readReg(4'd5, v);
      check("unmapped", v, 32'h0);
      writeReg(4'd9, 32'hABC);
      readReg(4'd9, v);
      check("cap_readonly", v, 32'h0);

      doReset();
      writeReg(4'd0, 32'd1);
      writeReg(4'd4, $urandom);
      randomPhase(1500);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule

// File: doc/mc_timer.md
MC_TIMER -- requirements
Module: mc_timer

Interface
REQ-001 Parameter WIDTH, default 32, counter/compare/capture/data width (8..32).
REQ-002 Parameter CHANNELS, default 4, number of compare/capture channels (1..4).
REQ-003 Port clk  input  1  clock; all logic on rising edge.
REQ-004 Port rst  input  1  reset, synchronous, active-high.
REQ-005 Port timer_rst  input  1  synchronous clear of counter and prescaler only.
REQ-006 Port addr  input  4  register address.
REQ-007 Port wr_en  input  1  register write strobe.
REQ-008 Port rd_en  input  1  register read strobe.
REQ-009 Port wr_data  input  WIDTH  write data.
REQ-010 Port rd_data  output  WIDTH  read data, registered.
REQ-011 Port rd_valid  output  1  rd_data valid, one-cycle pulse.
REQ-012 Port cap_in  input  CHANNELS  asynchronous capture inputs.
REQ-013 Port irq  output  1  level interrupt.
REQ-014 Port count  output  WIDTH  current counter value.

Function
REQ-015 Register map: 0 CTRL, 1 PRESCALE, 2 COUNT, 3 STATUS, 4 IRQ_EN, 8+2k CMPk, 9+2k CAPk (k < CHANNELS); other addresses read 0, writes ignored.
REQ-016 CTRL bits: [0] EN, [1] PERIOD (wrap at CMP0), [2] ONESHOT; other bits read 0.
REQ-017 STATUS bits: [k] compare match k, [8+k] capture k, [16] overflow; bits are sticky and write-1-to-clear.
REQ-018 Read: rd_en in cycle N gives rd_data and rd_valid=1 in cycle N+1; rd_data holds its value otherwise.
REQ-019 If rd_en and wr_en are both high, the write is performed and the read returns the pre-write value.
REQ-020 Prescaler counter pcnt runs only while EN=1; tick is high when pcnt==PRESCALE, and pcnt then returns to 0; PRESCALE=0 ticks every cycle.
REQ-021 On tick with PERIOD=1 and count==CMP0: count goes to 0; if ONESHOT=1, EN clears in the same cycle.
REQ-022 On tick otherwise: count increments modulo 2^WIDTH; on all-ones to 0, STATUS[16] sets.
REQ-023 Compare k: on tick with pre-tick count==CMPk, STATUS[k] sets.
REQ-024 Capture k: cap_in[k] passes a 2-FF synchroniser plus rising-edge detect; on an edge, CAPk loads count and STATUS[8+k] sets, independent of EN.
REQ-025 CAPk registers are read-only; writes to them are ignored.
REQ-026 Count priority, highest first: rst, timer_rst, COUNT register write, tick update.
REQ-027 A COUNT write or timer_rst also clears pcnt to 0.
REQ-028 Status priority: a hardware set in the same cycle as a W1C clear of that bit wins (bit stays 1).
REQ-029 irq = |(STATUS & IRQ_EN), combinational from registers.
REQ-030 Writes to CTRL/PRESCALE/CMPk take effect from the next cycle.

Reset
REQ-031 On rst, CTRL, PRESCALE, COUNT, pcnt, STATUS, IRQ_EN, all CMPk, all CAPk, rd_data, rd_valid and synchroniser flops SHALL be 0; irq=0 and count=0 the cycle after rst.
REQ-032 rst asserted mid-count SHALL abort operation; pending edges are discarded; no status is set in the reset cycle.
REQ-033 timer_rst SHALL NOT alter CTRL, STATUS, CMPk, CAPk or IRQ_EN.

Verification
REQ-034 PRESCALE=3, CTRL=1, run 40 cycles -> count=10 (one increment per 4 cycles).
REQ-035 CMP0=5, CTRL=0b111, PRESCALE=0 -> count 0..5, wraps to 0, EN reads 0, STATUS[0]=1; with IRQ_EN[0]=1, irq=1 until STATUS write 0x1.
REQ-036 COUNT write 0xFFFFFFFE, EN=1, PRESCALE=0 -> overflow after 2 ticks, STATUS[16]=1, count=0.
REQ-037 cap_in[2] rises while count=0x40 -> CAP2 = count value 3 cycles after the edge (sync latency), STATUS[10]=1.
REQ-038 STATUS W1C of bit 0 in the same cycle as a new compare-0 match -> STATUS[0] remains 1.
REQ-039 rd_en on CMP1 while writing CMP1=7 -> rd_valid next cycle with old value; a subsequent read returns 7.
